// File: rtl/gf_mul_ctrl_pkg.sv
// Shared types and helpers for the bit-serial GF(2^m) multiplier.
// Includes the FSM state encoding and the field-grade legality check.
package gf_pkg;

  localparam int GF_DATA_WIDTH = 10;
  localparam int GRADE_W = $clog2(GF_DATA_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // A field needs at least degree 2 and must fit the datapath.
  function automatic logic grade_legal(input int grade, input int max_deg);
    return (grade >= 2) && (grade <= max_deg);
  endfunction

endpackage

// File: rtl/gf_mul_ctrl_mac_step.sv
// One MSB-first multiply iteration: shift the accumulator, reduce by poly,
// then fold in the multiplicand when the current multiplier bit is set.
module gf_mac_step
  import gf_pkg::*;
#(
  parameter int DATA_WIDTH = 10
) (
  input  logic [DATA_WIDTH-1:0]       acc,
  input  logic [DATA_WIDTH-1:0]       a,
  input  logic [DATA_WIDTH:0]         poly,
  input  logic [$clog2(DATA_WIDTH):0] grade,
  input  logic                        b_bit,
  output logic [DATA_WIDTH-1:0]       acc_next
);

  logic [DATA_WIDTH:0] t;
  logic                lead;

  always_comb begin
    t = {acc, 1'b0};
    // The leading term sits at bit[grade]; reduce before adding a.
    lead = |(t & ((DATA_WIDTH + 1)'(1) << grade));
    if (lead) begin
      t = t ^ poly;
    end
    if (b_bit) begin
      t = t ^ {1'b0, a};
    end
    acc_next = t[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/gf_mul_ctrl.sv
// Bit-serial GF(2^m) multiplier controller: takes one request, runs grade
// iterations, then holds the reduced product until the consumer takes it.
module gf_mul_ctrl
  import gf_pkg::*;
#(
  parameter int DATA_WIDTH = 10
) (
  input  logic                        clk,
  input  logic                        rst_l,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH-1:0]       in_a,
  input  logic [DATA_WIDTH-1:0]       in_b,
  input  logic [DATA_WIDTH:0]         in_poly,
  input  logic [$clog2(DATA_WIDTH):0] in_grade,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_err
);

  localparam int GW = $clog2(DATA_WIDTH) + 1;

  state_t                state;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH:0]   poly_q;
  logic [GW-1:0]         grade_q;
  logic [GW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] acc_next;
  logic [DATA_WIDTH-1:0] a_mask;
  logic [DATA_WIDTH:0]   p_mask;
  logic                  accept;
  logic                  legal;
  logic                  b_bit;

  // Flush and reset both close the input so neither can race a new request.
  assign in_ready = rst_l && !flush &&
                    ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept   = in_valid && in_ready;
  assign legal    = grade_legal(int'(in_grade), DATA_WIDTH);
  assign b_bit    = |(b_q & (DATA_WIDTH'(1) << cnt));

  always_comb begin
    a_mask = '0;
    p_mask = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      a_mask[i] = (i < int'(in_grade));
    end
    for (int i = 0; i <= DATA_WIDTH; i++) begin
      p_mask[i] = (i <= int'(in_grade));
    end
  end

  gf_mac_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .acc     (acc),
    .a       (a_q),
    .poly    (poly_q),
    .grade   (grade_q),
    .b_bit   (b_bit),
    .acc_next(acc_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      poly_q    <= '0;
      grade_q   <= '0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
    end else if (accept) begin
      // Accept is only possible from IDLE or a DONE handshake.
      a_q     <= in_a & a_mask;
      b_q     <= in_b & a_mask;
      poly_q  <= in_poly & p_mask;
      grade_q <= in_grade;
      acc     <= '0;
      cnt     <= in_grade - GW'(1);
      if (legal) begin
        state     <= RUN;
        out_valid <= 1'b0;
        out_err   <= 1'b0;
      end else begin
        state     <= DONE;
        out_valid <= 1'b1;
        out_data  <= '0;
        out_err   <= 1'b1;
      end
    end else begin
      case (state)
        RUN: begin
          acc <= acc_next;
          if (cnt == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_data  <= acc_next;
            out_err   <= 1'b0;
          end else begin
            cnt <= cnt - GW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf_mul_ctrl.sv
// Bench for gf_mul_ctrl: fixed vectors, handshake/flush/reset corners, and
// random requests checked against a multiply-then-divide reference.
module tb_gf_mul_ctrl;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_a;
  logic [9:0]  in_b;
  logic [10:0] in_poly;
  logic [4:0]  in_grade;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_data;
  logic        out_err;

  int n_chk  = 0;
  int n_fail = 0;

  gf_mul_ctrl #(.DATA_WIDTH(10)) dut (
    .clk      (clk),
    .rst_l    (rst_l),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_poly  (in_poly),
    .in_grade (in_grade),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_err  (out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  a;
    logic [9:0]  b;
    logic [10:0] poly;
    logic [4:0]  grade;
    logic [9:0]  exp_data;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Schoolbook carry-less product followed by polynomial long division.
  function automatic logic [9:0] ref_mul(input logic [9:0] a, input logic [9:0] b,
                                         input logic [10:0] poly, input int g);
    int am, bm, pm, p;
    if (g < 2 || g > 10) return 10'h0;
    am = int'(a) & ((1 << g) - 1);
    bm = int'(b) & ((1 << g) - 1);
    pm = int'(poly) & ((1 << (g + 1)) - 1);
    p = 0;
    for (int i = 0; i < g; i++)
      if (((bm >> i) & 1) == 1) p = p ^ (am << i);
    for (int i = 2 * g - 2; i >= g; i--)
      if (((p >> i) & 1) == 1) p = p ^ (pm << (i - g));
    return 10'(p);
  endfunction

  // Called at a negedge with the block idle; returns at the negedge after accept.
  task automatic send_op(input logic [9:0] a, input logic [9:0] b,
                         input logic [10:0] poly, input logic [4:0] grade);
    int k;
    in_a = a; in_b = b; in_poly = poly; in_grade = grade; in_valid = 1'b1;
    #1;
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("accept_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_op(input logic [9:0] a, input logic [9:0] b,
                          input logic [10:0] poly, input logic [4:0] grade,
                          input logic [9:0] exp_data, input logic exp_err,
                          input int hold, input string nm);
    int lat;
    int exp_lat;
    exp_lat = exp_err ? 1 : int'(grade) + 1;
    out_ready = 1'b0;
    send_op(a, b, poly, grade);
    wait_result(lat);
    chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_data"}, 32'(out_data), 32'(exp_data));
    chk({nm, "_err"}, 32'(out_err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({nm, "_hold_data"}, 32'(out_data), 32'(exp_data));
      chk({nm, "_hold_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk({nm, "_post_valid"}, 32'(out_valid), 32'd0);
    chk({nm, "_post_ready"}, 32'(in_ready), 32'd1);
  endtask

  vec_t vecs[8];

  initial begin
    int lat;
    int seen;
    int g;
    logic [9:0]  ra, rb, rexp;
    logic [10:0] rp;
    logic        rerr;

    vecs[0] = '{10'h002, 10'h008, 11'h013, 5'd4, 10'h003, 1'b0};
    vecs[1] = '{10'h057, 10'h083, 11'h11B, 5'd8, 10'h0C1, 1'b0};
    vecs[2] = '{10'h057, 10'h013, 11'h11B, 5'd8, 10'h0FE, 1'b0};
    vecs[3] = '{10'h005, 10'h007, 11'h013, 5'd1, 10'h000, 1'b1};
    vecs[4] = '{10'h005, 10'h007, 11'h013, 5'd11, 10'h000, 1'b1};
    vecs[5] = '{10'h200, 10'h002, 11'h409, 5'd10, 10'h009, 1'b0};
    vecs[6] = '{10'h002, 10'h002, 11'h007, 5'd2, 10'h003, 1'b0};
    vecs[7] = '{10'h3F2, 10'h3F8, 11'h7D3, 5'd4, 10'h003, 1'b0};

    rst_l = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_poly = '0; in_grade = '0;
    repeat (2) @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    chk("reset_out_err", 32'(out_err), 32'd0);
    rst_l = 1'b1;
    #1;
    chk("reset_release_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      check_op(vecs[i].a, vecs[i].b, vecs[i].poly, vecs[i].grade,
               vecs[i].exp_data, vecs[i].exp_err, 1, $sformatf("vec%0d", i));

    // Stall six cycles in DONE, then a back-to-back handshake plus accept.
    send_op(10'h002, 10'h008, 11'h013, 5'd4);
    wait_result(lat);
    chk("b2b_first_latency", 32'(lat), 32'd5);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("b2b_stall_data", 32'(out_data), 32'h3);
      chk("b2b_stall_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    in_a = 10'h003; in_b = 10'h003; in_poly = 11'h013; in_grade = 5'd4; in_valid = 1'b1;
    #1;
    chk("b2b_same_edge_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_valid_drop", 32'(out_valid), 32'd0);
    wait_result(lat);
    chk("b2b_second_latency", 32'(lat), 32'd5);
    chk("b2b_second_data", 32'(out_data), 32'h5);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Flush in RUN cycle 3 of a grade-8 op, racing a new request.
    send_op(10'h057, 10'h083, 11'h11B, 5'd8);
    repeat (2) @(negedge clk);
    flush = 1'b1;
    in_a = 10'h003; in_b = 10'h003; in_poly = 11'h013; in_grade = 5'd4; in_valid = 1'b1;
    #1;
    chk("flush_blocks_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_idle_ready", 32'(in_ready), 32'd1);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("flush_no_result", 32'(seen), 32'd0);

    // Reset while holding a result in DONE.
    send_op(10'h002, 10'h008, 11'h013, 5'd4);
    wait_result(lat);
    chk("rst_done_valid", 32'(out_valid), 32'd1);
    rst_l = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_low_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_still_low_ready", 32'(in_ready), 32'd0);
    rst_l = 1'b1; out_ready = 1'b0;
    #1;
    chk("rst_release_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) g = $urandom_range(0, 15);
      else g = $urandom_range(2, 10);
      ra = 10'($urandom);
      rb = 10'($urandom);
      rp = 11'($urandom);
      if (g >= 2 && g <= 10) rp[g] = 1'b1;
      rerr = (g < 2 || g > 10);
      rexp = ref_mul(ra, rb, rp, g);
      check_op(ra, rb, rp, 5'(g), rexp, rerr, $urandom_range(0, 2),
               $sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
